// File: rtl/led_pattern_sequencer.sv
// Sequencer for the LED pattern datapath: cycles FLASH -> SHIFT_L -> SHIFT_R on slow ticks.
// Define LED_SEQ_PAUSE_EN to insert a blanked PAUSE state before each tick-driven mode change.
module led_pattern_sequencer #(
    parameter int DWELL_TICKS = 8,
    parameter int PAUSE_TICKS = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start,
    input  logic       stop,
    input  logic       step,
    output logic       func_sel,
    output logic       shift_sel,
    output logic       dp_reset,
    output logic       blank,
    output logic [1:0] mode,
    output logic       busy
);

    localparam int MAX_TICKS = (DWELL_TICKS > PAUSE_TICKS) ? DWELL_TICKS : PAUSE_TICKS;
    localparam int CNT_W     = $clog2(MAX_TICKS + 1);

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_TICKS - 1);
`ifdef LED_SEQ_PAUSE_EN
    localparam logic [CNT_W-1:0] PAUSE_LAST = CNT_W'(PAUSE_TICKS - 1);
`endif

    // Run-state encodings equal the value shown on `mode`.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FLASH   = 3'd1,
        ST_SHIFT_L = 3'd2,
        ST_SHIFT_R = 3'd3
`ifdef LED_SEQ_PAUSE_EN
        , ST_PAUSE = 3'd4
`endif
    } state_t;

    typedef struct packed {
        logic       func_sel;
        logic       shift_sel;
        logic       dp_reset;
        logic       blank;
        logic [1:0] mode;
        logic       busy;
    } out_t;

    localparam out_t IDLE_OUT = '{
        func_sel: 1'b0, shift_sel: 1'b0, dp_reset: 1'b1,
        blank: 1'b1, mode: 2'd0, busy: 1'b0
    };

    function automatic state_t next_run(input state_t s);
        case (s)
            ST_FLASH:   next_run = ST_SHIFT_L;
            ST_SHIFT_L: next_run = ST_SHIFT_R;
            default:    next_run = ST_FLASH;
        endcase
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    out_t             out_q, out_d;
    logic             run_state;
    logic             entering;
`ifdef LED_SEQ_PAUSE_EN
    state_t           upcoming_q, upcoming_d;
`endif

    // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
`ifdef LED_SEQ_PAUSE_EN
        upcoming_d = upcoming_q;
`endif
        run_state = (state_q == ST_FLASH) || (state_q == ST_SHIFT_L) || (state_q == ST_SHIFT_R);

        if (stop) begin
            state_d = ST_IDLE;
        end else if (step && run_state) begin
            state_d = next_run(state_q);
`ifdef LED_SEQ_PAUSE_EN
        end else if (step && (state_q == ST_PAUSE)) begin
            state_d = upcoming_q;
        end else if (tick && run_state && (cnt_q == DWELL_LAST)) begin
            state_d    = ST_PAUSE;
            upcoming_d = next_run(state_q);
        end else if (tick && (state_q == ST_PAUSE) && (cnt_q == PAUSE_LAST)) begin
            state_d = upcoming_q;
`else
        end else if (tick && run_state && (cnt_q == DWELL_LAST)) begin
            state_d = next_run(state_q);
`endif
        end else if (start && (state_q == ST_IDLE)) begin
            state_d = ST_FLASH;
        end

        // Every transition changes state, so a state change marks a fresh entry.
        entering = (state_d != state_q);

        if (entering || (state_d == ST_IDLE)) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Outputs are decoded from the next state and registered, so no input reaches an output combinationally.
    always_comb begin
        out_d = IDLE_OUT;
        case (state_d)
            ST_FLASH, ST_SHIFT_L, ST_SHIFT_R: begin
                out_d.func_sel  = (state_d == ST_FLASH);
                out_d.shift_sel = (state_d == ST_SHIFT_R);
                out_d.dp_reset  = entering;
                out_d.blank     = 1'b0;
                out_d.mode      = state_d[1:0];
                out_d.busy      = 1'b1;
            end
`ifdef LED_SEQ_PAUSE_EN
            ST_PAUSE: begin
                out_d.func_sel  = out_q.func_sel;
                out_d.shift_sel = out_q.shift_sel;
                out_d.dp_reset  = 1'b1;
                out_d.blank     = 1'b1;
                out_d.mode      = upcoming_d[1:0];
                out_d.busy      = 1'b1;
            end
`endif
            default: out_d = IDLE_OUT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            out_q   <= IDLE_OUT;
`ifdef LED_SEQ_PAUSE_EN
            upcoming_q <= ST_FLASH;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
`ifdef LED_SEQ_PAUSE_EN
            upcoming_q <= upcoming_d;
`endif
        end
    end

    assign func_sel  = out_q.func_sel;
    assign shift_sel = out_q.shift_sel;
    assign dp_reset  = out_q.dp_reset;
    assign blank     = out_q.blank;
    assign mode      = out_q.mode;
    assign busy      = out_q.busy;

endmodule
